// File: rtl/serial_atree.sv
// Serial adder tree: accumulates N = 2**LEVELS unsigned operands, one per
// accepted beat, then holds the completed sum until downstream takes it.
module serial_atree #(
    parameter int IN_WIDTH = 8,
    parameter int LEVELS   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [IN_WIDTH-1:0]        in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [IN_WIDTH+LEVELS-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LEVELS-1:0]          count
);

    localparam int SUM_W = IN_WIDTH + LEVELS;
    // count is exactly LEVELS bits, so the last operand index is all ones
    localparam logic [LEVELS-1:0] LAST = '1;

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state;
    logic [SUM_W-1:0] acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        acc   <= acc + SUM_W'(in_data);
                        count <= count + LEVELS'(1);
                        if (count == LAST) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // sum is frozen here; only the output handshake leaves
                    if (out_ready) begin
                        acc       <= '0;
                        count     <= '0;
                        state     <= ACCUM;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign in_ready = (state == ACCUM);
    assign out_data = acc;

endmodule
